// File: rtl/proc_fetch_pkg.sv
// Shared types and constants for the TinyRV1 instruction fetch stage.
// Optional build macro: PROC_FETCH_BYPASS_EN (used by proc_fetch_unit).
package proc_fetch_pkg;

  // One fetched instruction together with the PC it was read from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Sequential fetch advances one 32-bit word at a time.
  localparam logic [31:0] PC_INCR = 32'd4;

  // PC the core starts from when no override is given.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Redirect targets are word aligned by dropping the low two bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/proc_fetch_unit_if.sv
// Bundle of the fetch stage's memory, redirect and decode-side signals.
// master: the fetch unit. slave: the surrounding memory/decode environment.
interface proc_fetch_unit_if;

  logic        imemreq_val;
  logic [31:0] imemreq_addr;
  logic [31:0] imemresp_data;
  logic        redirect_val;
  logic [31:0] redirect_target;
  logic        f2d_val;
  logic        f2d_rdy;
  logic [31:0] f2d_pc;
  logic [31:0] f2d_inst;

  modport master (
    output imemreq_val, imemreq_addr, f2d_val, f2d_pc, f2d_inst,
    input  imemresp_data, redirect_val, redirect_target, f2d_rdy
  );

  modport slave (
    input  imemreq_val, imemreq_addr, f2d_val, f2d_pc, f2d_inst,
    output imemresp_data, redirect_val, redirect_target, f2d_rdy
  );

endinterface

// File: rtl/fetch_queue.sv
// Small circular FIFO of {pc, inst} entries sitting between fetch and decode.
// Push and pop may happen together even when full; flush beats both.
module fetch_queue
  import proc_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           push_data,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  fetch_entry_t     slots [DEPTH];

  // Pointers and occupancy; a flush empties the queue regardless of push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Entry storage; when full with a same-cycle pop the write reuses the slot being vacated.
  always_ff @(posedge clk) begin
    if (push && !flush) slots[wr_ptr] <= push_data;
  end

  assign head = slots[rd_ptr];

endmodule

// File: rtl/proc_fetch_unit.sv
// TinyRV1 instruction fetch stage: owns the PC, reads one word per cycle from
// a combinational instruction memory and queues {pc, inst} for decode.
// Build macro PROC_FETCH_BYPASS_EN adds a zero-latency path around an empty queue.
module proc_fetch_unit
  import proc_fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic                clk,
  input logic                rst,
  proc_fetch_unit_if.master  fif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          q_empty;
  logic          q_full;
  logic          q_val;
  logic          q_deq;
  logic          fetch_go;
  logic          push;
  logic          bypass;

  // The queue's own deq is computed without the bypass path so fetch_go never loops on itself.
  assign q_empty  = (count == '0);
  assign q_full   = (count == CW'(DEPTH));
  assign q_val    = ~q_empty & ~fif.redirect_val & ~rst;
  assign q_deq    = q_val & fif.f2d_rdy;
  assign fetch_go = ~rst & ~fif.redirect_val & (~q_full | q_deq);

`ifdef PROC_FETCH_BYPASS_EN
  assign bypass = q_empty & fetch_go & fif.f2d_rdy;
`else
  assign bypass = 1'b0;
`endif

  assign push            = fetch_go & ~bypass;
  assign push_entry.pc   = pc;
  assign push_entry.inst = fif.imemresp_data;

  assign fif.imemreq_val  = fetch_go;
  assign fif.imemreq_addr = pc;
  assign fif.f2d_val      = q_val | bypass;
  assign fif.f2d_pc       = bypass ? pc : head.pc;
  assign fif.f2d_inst     = bypass ? fif.imemresp_data : head.inst;

  // PC update: redirect wins, otherwise advance by one word on every issued fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (fif.redirect_val) begin
      pc <= align_word(fif.redirect_target);
    end else if (fetch_go) begin
      pc <= pc + PC_INCR;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (q_deq),
    .flush     (fif.redirect_val),
    .push_data (push_entry),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_proc_fetch_unit.sv
// Scoreboard bench for proc_fetch_unit: directed scenarios push the expected
// {pc, inst} deliveries, and a negedge monitor checks every decode handshake.
module tb_proc_fetch_unit;
  import proc_fetch_pkg::*;

  logic clk;
  logic rst;
  proc_fetch_unit_if fif ();

  int n_compared   = 0;
  int n_mismatched = 0;
  int delivered    = 0;
  fetch_entry_t sb [$];
  fetch_entry_t mon_exp;

  proc_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents: upper half is the inverted address, lower half the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign fif.imemresp_data = mem_word(fif.imemreq_addr);

  // Monitor: every accepted instruction must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && fif.f2d_val && fif.f2d_rdy) begin
      delivered++;
      n_compared++;
      if (sb.size() == 0) begin
        n_mismatched++;
        $display("[TB] FAIL f2d_unexpected: got pc=%h inst=%h, required no delivery",
                 fif.f2d_pc, fif.f2d_inst);
      end else begin
        mon_exp = sb.pop_front();
        if (fif.f2d_pc !== mon_exp.pc || fif.f2d_inst !== mon_exp.inst) begin
          n_mismatched++;
          $display("[TB] FAIL f2d_entry: got pc=%h inst=%h, required pc=%h inst=%h",
                   fif.f2d_pc, fif.f2d_inst, mon_exp.pc, mon_exp.inst);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic rdy, input logic rv, input logic [31:0] target);
    fif.f2d_rdy         = rdy;
    fif.redirect_val    = rv;
    fif.redirect_target = target;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] inst);
    fetch_entry_t e;
    e.pc   = pc;
    e.inst = inst;
    sb.push_back(e);
  endtask

  // Hold ready high until n more instructions have been accepted, then drop it.
  task automatic consume(input int n);
    int target;
    bit done;
    target = delivered + n;
    done = 1'b0;
    fif.f2d_rdy = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      next_cycle();
      if (delivered >= target) done = 1'b1;
    end
    fif.f2d_rdy = 1'b0;
    n_compared++;
    if (!done) begin
      n_mismatched++;
      $display("[TB] FAIL consume_timeout: got %0d deliveries, required %0d", delivered, target);
    end
  endtask

  // One-cycle redirect pulse; in that cycle nothing may be fetched or delivered.
  task automatic redirect_pulse(input logic [31:0] target);
    apply_stimulus(fif.f2d_rdy, 1'b1, target);
    @(negedge clk);
    check_output("redir_imemreq_val", 32'(fif.imemreq_val), 32'd0);
    check_output("redir_f2d_val", 32'(fif.f2d_val), 32'd0);
    next_cycle();
    fif.redirect_val = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 32'h0);

    // Reset state
    @(negedge clk);
    check_output("rst_imemreq_val", 32'(fif.imemreq_val), 32'd0);
    check_output("rst_f2d_val", 32'(fif.f2d_val), 32'd0);
    check_output("rst_imemreq_addr", fif.imemreq_addr, 32'h0);

    // Streaming with decode always ready
    @(posedge clk);
    #1;
    rst = 1'b0;
    fif.f2d_rdy = 1'b1;
    expect_entry(32'h0, 32'hFFFF_0000);
    expect_entry(32'h4, 32'hFFFB_0004);
    expect_entry(32'h8, 32'hFFF7_0008);
    expect_entry(32'hC, 32'hFFF3_000C);
    @(negedge clk);
    check_output("first_imemreq_val", 32'(fif.imemreq_val), 32'd1);
    check_output("first_imemreq_addr", fif.imemreq_addr, 32'h0);
`ifdef PROC_FETCH_BYPASS_EN
    check_output("first_f2d_val_latency", 32'(fif.f2d_val), 32'd1);
`else
    check_output("first_f2d_val_latency", 32'(fif.f2d_val), 32'd0);
`endif
    consume(4);

    // Decode stalled: two fetches fill the queue, then the PC stops at 8
    redirect_pulse(32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("stall_imemreq_val", 32'(fif.imemreq_val), (i < 2) ? 32'd1 : 32'd0);
      if (i == 2) check_output("stall_pc", fif.imemreq_addr, 32'h8);
      if (i >= 1) begin
        check_output("stall_f2d_val", 32'(fif.f2d_val), 32'd1);
        check_output("stall_f2d_pc", fif.f2d_pc, 32'h0);
      end
      next_cycle();
    end
    expect_entry(32'h0, mem_word(32'h0));
    expect_entry(32'h4, mem_word(32'h4));
    expect_entry(32'h8, mem_word(32'h8));
    consume(3);

    // Redirect with a full queue to an unaligned target
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_output("full_f2d_val", 32'(fif.f2d_val), 32'd1);
    check_output("full_imemreq_val", 32'(fif.imemreq_val), 32'd0);
    next_cycle();
    redirect_pulse(32'h0000_0043);
    @(negedge clk);
    check_output("post_redir_addr", fif.imemreq_addr, 32'h40);
    check_output("post_redir_imemreq_val", 32'(fif.imemreq_val), 32'd1);
    check_output("post_redir_empty", 32'(fif.f2d_val), 32'd0);
    next_cycle();
    expect_entry(32'h40, mem_word(32'h40));
    consume(1);

    // PC wraps from the top of the address space
    redirect_pulse(32'hFFFF_FFFC);
    @(negedge clk);
    check_output("wrap_addr0", fif.imemreq_addr, 32'hFFFF_FFFC);
    check_output("wrap_val0", 32'(fif.imemreq_val), 32'd1);
    next_cycle();
    @(negedge clk);
    check_output("wrap_addr1", fif.imemreq_addr, 32'h0);
    check_output("wrap_val1", 32'(fif.imemreq_val), 32'd1);
    next_cycle();
    expect_entry(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
    expect_entry(32'h0, mem_word(32'h0));
    consume(2);

    // Asynchronous reset in the middle of a cycle with a full queue
    next_cycle();
    next_cycle();
    fif.f2d_rdy = 1'b1;
    #1;
    check_output("pre_rst_imemreq_val", 32'(fif.imemreq_val), 32'd1);
    check_output("pre_rst_f2d_val", 32'(fif.f2d_val), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_output("async_rst_imemreq_val", 32'(fif.imemreq_val), 32'd0);
    check_output("async_rst_f2d_val", 32'(fif.f2d_val), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fif.f2d_rdy = 1'b0;
    @(negedge clk);
    check_output("resume_addr", fif.imemreq_addr, 32'h0);
    check_output("resume_val", 32'(fif.imemreq_val), 32'd1);
    next_cycle();
    expect_entry(32'h0, mem_word(32'h0));
    consume(1);

    // Back-to-back redirects: the later target wins
    apply_stimulus(1'b0, 1'b1, 32'h20);
    @(negedge clk);
    check_output("b2b_val0", 32'(fif.imemreq_val), 32'd0);
    next_cycle();
    apply_stimulus(1'b0, 1'b1, 32'h80);
    @(negedge clk);
    check_output("b2b_val1", 32'(fif.imemreq_val), 32'd0);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("b2b_addr", fif.imemreq_addr, 32'h80);
    check_output("b2b_val2", 32'(fif.imemreq_val), 32'd1);
    next_cycle();
    expect_entry(32'h80, mem_word(32'h80));
    consume(1);

    // Nothing expected may remain undelivered
    next_cycle();
    next_cycle();
    check_output("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
